// File: rtl/system_top_entity_if.sv
// Observation bundle for the core: architectural registers x1..x10.
interface system_top_entity_if;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [31:0] reg3;
  logic [31:0] reg4;
  logic [31:0] reg5;
  logic [31:0] reg6;
  logic [31:0] reg7;
  logic [31:0] reg8;
  logic [31:0] reg9;
  logic [31:0] reg10;

  modport master (output reg1, reg2, reg3, reg4, reg5, reg6, reg7, reg8, reg9, reg10);
  modport slave  (input  reg1, reg2, reg3, reg4, reg5, reg6, reg7, reg8, reg9, reg10);
endinterface

// File: rtl/system_top_entity.sv
// Single-cycle RV32I-subset core with instruction ROM and data RAM.
// One instruction retires per clock; x1..x10 are exported for debug.
// CUSTOM_ROM selects ROM_IMAGE (word i at bits [i*32 +: 32]) instead of the built-in program.
module system_top_entity #(
  parameter int                      IMEM_WORDS = 64,
  parameter int                      DMEM_WORDS = 64,
  parameter bit                      CUSTOM_ROM = 1'b0,
  parameter logic [IMEM_WORDS*32-1:0] ROM_IMAGE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  system_top_entity_if.master  dbg
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] pc_r;
  logic [31:0] rf_r   [32];
  logic [31:0] dmem_r [DMEM_WORDS];

  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;
  logic [31:0] ld_addr_s;
  logic [31:0] st_addr_s;
  logic [31:0] next_pc_s;
  logic        rd_we_s;
  logic [31:0] rd_data_s;
  logic        mem_we_s;
  logic        take_s;

  // Built-in program; unlisted words are NOP (addi x0,x0,0).
  function automatic logic [31:0] default_rom(input logic [IW-1:0] idx);
    case (32'(idx))
      32'd0:   return 32'h00500093; // addi x1,x0,5
      32'd1:   return 32'h00700113; // addi x2,x0,7
      32'd2:   return 32'h002081B3; // add  x3,x1,x2
      32'd3:   return 32'h40110233; // sub  x4,x2,x1
      32'd4:   return 32'h123452B7; // lui  x5,0x12345
      32'd5:   return 32'h00302023; // sw   x3,0(x0)
      32'd6:   return 32'h00002303; // lw   x6,0(x0)
      32'd7:   return 32'h00138393; // addi x7,x7,1
      32'd8:   return 32'hFE239EE3; // bne  x7,x2,-4
      32'd9:   return 32'h0000046F; // jal  x8,0
      default: return 32'h00000013;
    endcase
  endfunction

  // Shared ALU for OP and OP-IMM; sub_en selects SUB, alt selects arithmetic right shift.
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, input logic sub_en, input logic alt);
    case (f3)
      3'b000:  return sub_en ? (a - b) : (a + b);
      3'b001:  return a << b[4:0];
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign instr_s   = CUSTOM_ROM ? ROM_IMAGE[int'(pc_r[IW+1:2])*32 +: 32] : default_rom(pc_r[IW+1:2]);
  assign opcode_s  = instr_s[6:0];
  assign funct3_s  = instr_s[14:12];
  assign rd_s      = instr_s[11:7];
  assign rs1_s     = instr_s[19:15];
  assign rs2_s     = instr_s[24:20];
  assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : rf_r[rs1_s];
  assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : rf_r[rs2_s];
  assign imm_i_s   = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s   = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s   = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s   = {instr_s[31:12], 12'd0};
  assign imm_j_s   = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
  assign ld_addr_s = rs1_val_s + imm_i_s;
  assign st_addr_s = rs1_val_s + imm_s_s;

  // Branch condition evaluation.
  always_comb begin
    take_s = 1'b0;
    case (funct3_s)
      3'b000:  take_s = (rs1_val_s == rs2_val_s);
      3'b001:  take_s = (rs1_val_s != rs2_val_s);
      3'b100:  take_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
      3'b101:  take_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
      3'b110:  take_s = (rs1_val_s <  rs2_val_s);
      3'b111:  take_s = (rs1_val_s >= rs2_val_s);
      default: take_s = 1'b0;
    endcase
  end

  // Decode/execute: next pc, register write-back and store enable; unknown opcodes fall through as NOP.
  always_comb begin
    next_pc_s = pc_r + 32'd4;
    rd_we_s   = 1'b0;
    rd_data_s = 32'd0;
    mem_we_s  = 1'b0;
    case (opcode_s)
      7'b0110111: begin
        rd_we_s   = 1'b1;
        rd_data_s = imm_u_s;
      end
      7'b0010111: begin
        rd_we_s   = 1'b1;
        rd_data_s = pc_r + imm_u_s;
      end
      7'b1101111: begin
        rd_we_s   = 1'b1;
        rd_data_s = pc_r + 32'd4;
        next_pc_s = pc_r + imm_j_s;
      end
      7'b1100111: begin
        if (funct3_s == 3'b000) begin
          rd_we_s   = 1'b1;
          rd_data_s = pc_r + 32'd4;
          next_pc_s = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;
        end else begin
          rd_we_s = 1'b0;
        end
      end
      7'b1100011: begin
        if (take_s) begin
          next_pc_s = pc_r + imm_b_s;
        end else begin
          next_pc_s = pc_r + 32'd4;
        end
      end
      7'b0000011: begin
        if (funct3_s == 3'b010) begin
          rd_we_s   = 1'b1;
          rd_data_s = dmem_r[ld_addr_s[DW+1:2]];
        end else begin
          rd_we_s = 1'b0;
        end
      end
      7'b0100011: begin
        if (funct3_s == 3'b010) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      7'b0010011: begin
        rd_we_s   = 1'b1;
        rd_data_s = alu(funct3_s, rs1_val_s, imm_i_s, 1'b0, instr_s[30]);
      end
      7'b0110011: begin
        rd_we_s   = 1'b1;
        rd_data_s = alu(funct3_s, rs1_val_s, rs2_val_s, instr_s[30], instr_s[30]);
      end
      default: begin
        rd_we_s = 1'b0;
      end
    endcase
  end

  // Architectural state: pc and register file, cleared by reset; x0 is never written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rf_r[i] <= 32'd0;
      end
    end else begin
      pc_r <= next_pc_s;
      if (rd_we_s && (rd_s != 5'd0)) begin
        rf_r[rd_s] <= rd_data_s;
      end
    end
  end

  // Data RAM write port; contents survive reset but a store is suppressed during reset.
  always_ff @(posedge clk) begin
    if (reset && mem_we_s) begin
      dmem_r[st_addr_s[DW+1:2]] <= rs2_val_s;
    end
  end

  assign dbg.reg1  = rf_r[1];
  assign dbg.reg2  = rf_r[2];
  assign dbg.reg3  = rf_r[3];
  assign dbg.reg4  = rf_r[4];
  assign dbg.reg5  = rf_r[5];
  assign dbg.reg6  = rf_r[6];
  assign dbg.reg7  = rf_r[7];
  assign dbg.reg8  = rf_r[8];
  assign dbg.reg9  = rf_r[9];
  assign dbg.reg10 = rf_r[10];

endmodule

// File: tb/tb_system_top_entity.sv
// Directed bench: default-program core plus a second core running a custom ROM image.
module tb_system_top_entity;
  logic clk = 1'b0;
  logic rst_def = 1'b0;
  logic rst_cus = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Custom image, word 0 in the least significant position.
  localparam logic [64*32-1:0] CUSTOM_IMG = {
    {48{32'h00000013}},
    32'h0000006F,  // 0x3C jal  x0,0
    32'h00000497,  // 0x38 auipc x9,0
    32'hFFFFFFFF,  // 0x34 illegal
    32'h00000517,  // 0x30 auipc x10,0
    32'h00000013,  // 0x2C nop
    32'h05500493,  // 0x28 addi x9,x0,0x55 (skipped by jalr)
    32'h00038467,  // 0x24 jalr x8,0(x7)
    32'h03100393,  // 0x20 addi x7,x0,0x31
    32'h0050B333,  // 0x1C sltu x6,x1,x5
    32'hFFF00293,  // 0x18 addi x5,x0,-1
    32'h40315233,  // 0x14 sra  x4,x2,x3
    32'h00400193,  // 0x10 addi x3,x0,4
    32'h80000137,  // 0x0C lui  x2,0x80000
    32'h000080B3,  // 0x08 add  x1,x1,x0
    32'h00100093,  // 0x04 addi x1,x0,1
    32'h00900013   // 0x00 addi x0,x0,9
  };

  system_top_entity_if ifd ();
  system_top_entity_if ifc ();

  system_top_entity #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut_def (
    .clk(clk), .reset(rst_def), .dbg(ifd.master));

  system_top_entity #(.IMEM_WORDS(64), .DMEM_WORDS(64), .CUSTOM_ROM(1'b1), .ROM_IMAGE(CUSTOM_IMG)) dut_cus (
    .clk(clk), .reset(rst_cus), .dbg(ifc.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_def(input int k);
    case (k)
      1: return ifd.reg1;   2: return ifd.reg2;  3: return ifd.reg3;  4: return ifd.reg4;
      5: return ifd.reg5;   6: return ifd.reg6;  7: return ifd.reg7;  8: return ifd.reg8;
      9: return ifd.reg9;  10: return ifd.reg10;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] rd_cus(input int k);
    case (k)
      1: return ifc.reg1;   2: return ifc.reg2;  3: return ifc.reg3;  4: return ifc.reg4;
      5: return ifc.reg5;   6: return ifc.reg6;  7: return ifc.reg7;  8: return ifc.reg8;
      9: return ifc.reg9;  10: return ifc.reg10;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Advance one rising edge and settle at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_def = 1'b0;
    step();
    step();
    for (int k = 1; k <= 10; k++) begin
      n_cmp++;
      if (rd_def(k) !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_x%0d: got %h want %h", k, rd_def(k), 32'd0);
      end
    end
    rst_def = 1'b1;
    step();
    n_cmp++;
    if (ifd.reg1 !== 32'h5) begin n_bad++; $display("FAIL edge1_x1: got %h want %h", ifd.reg1, 32'h5); end
    step();
    n_cmp++;
    if (ifd.reg2 !== 32'h7) begin n_bad++; $display("FAIL edge2_x2: got %h want %h", ifd.reg2, 32'h7); end
  endtask

  task automatic test_arith();
    step();
    n_cmp++;
    if (ifd.reg3 !== 32'h0000000C) begin n_bad++; $display("FAIL add_x3: got %h want %h", ifd.reg3, 32'hC); end
    step();
    n_cmp++;
    if (ifd.reg4 !== 32'h00000002) begin n_bad++; $display("FAIL sub_x4: got %h want %h", ifd.reg4, 32'h2); end
    step();
    n_cmp++;
    if (ifd.reg5 !== 32'h12345000) begin n_bad++; $display("FAIL lui_x5: got %h want %h", ifd.reg5, 32'h12345000); end
  endtask

  task automatic test_memory();
    step();
    n_cmp++;
    if (ifd.reg6 !== 32'h0) begin n_bad++; $display("FAIL sw_x6: got %h want %h", ifd.reg6, 32'h0); end
    step();
    n_cmp++;
    if (ifd.reg6 !== 32'h0000000C) begin n_bad++; $display("FAIL lw_x6: got %h want %h", ifd.reg6, 32'hC); end
  endtask

  // Edges 8..40: x7 = min(7,(e-6)/2); x8 becomes 0x28 at edge 22.
  task automatic test_branch_loop();
    logic [31:0] exp7;
    logic [31:0] exp8;
    for (int e = 8; e <= 40; e++) begin
      step();
      exp7 = ((e - 6) / 2 > 7) ? 32'd7 : 32'((e - 6) / 2);
      exp8 = (e >= 22) ? 32'h28 : 32'h0;
      n_cmp++;
      if (ifd.reg7 !== exp7) begin n_bad++; $display("FAIL loop_x7_e%0d: got %h want %h", e, ifd.reg7, exp7); end
      n_cmp++;
      if (ifd.reg8 !== exp8) begin n_bad++; $display("FAIL loop_x8_e%0d: got %h want %h", e, ifd.reg8, exp8); end
    end
    n_cmp++;
    if ({ifd.reg1, ifd.reg2, ifd.reg3, ifd.reg4, ifd.reg5, ifd.reg6, ifd.reg9, ifd.reg10} !==
        {32'h5, 32'h7, 32'hC, 32'h2, 32'h12345000, 32'hC, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL final_state: got %h %h %h %h %h %h %h %h", ifd.reg1, ifd.reg2, ifd.reg3,
               ifd.reg4, ifd.reg5, ifd.reg6, ifd.reg9, ifd.reg10);
    end
  endtask

  task automatic test_midrun_reset();
    rst_def = 1'b0;
    step();
    rst_def = 1'b1;
    for (int e = 1; e <= 9; e++) step();
    n_cmp++;
    if (ifd.reg7 !== 32'h1) begin n_bad++; $display("FAIL rerun_x7: got %h want %h", ifd.reg7, 32'h1); end
    rst_def = 1'b0;
    step();
    for (int k = 1; k <= 10; k++) begin
      n_cmp++;
      if (rd_def(k) !== 32'd0) begin
        n_bad++;
        $display("FAIL midreset_x%0d: got %h want %h", k, rd_def(k), 32'd0);
      end
    end
    rst_def = 1'b1;
    step();
    n_cmp++;
    if (ifd.reg1 !== 32'h5 || ifd.reg2 !== 32'h0) begin
      n_bad++;
      $display("FAIL restart_e1: got x1=%h x2=%h want x1=%h x2=%h", ifd.reg1, ifd.reg2, 32'h5, 32'h0);
    end
    step();
    n_cmp++;
    if (ifd.reg2 !== 32'h7) begin n_bad++; $display("FAIL restart_e2: got %h want %h", ifd.reg2, 32'h7); end
  endtask

  task automatic test_custom_rom();
    rst_cus = 1'b0;
    step();
    rst_cus = 1'b1;
    for (int e = 1; e <= 3; e++) step();
    n_cmp++;
    if (ifc.reg1 !== 32'h1) begin n_bad++; $display("FAIL x0_write: got %h want %h", ifc.reg1, 32'h1); end
    for (int e = 4; e <= 6; e++) step();
    n_cmp++;
    if (ifc.reg4 !== 32'hF8000000) begin n_bad++; $display("FAIL sra: got %h want %h", ifc.reg4, 32'hF8000000); end
    for (int e = 7; e <= 8; e++) step();
    n_cmp++;
    if (ifc.reg6 !== 32'h1) begin n_bad++; $display("FAIL sltu: got %h want %h", ifc.reg6, 32'h1); end
    for (int e = 9; e <= 10; e++) step();
    n_cmp++;
    if (ifc.reg8 !== 32'h28) begin n_bad++; $display("FAIL jalr_link: got %h want %h", ifc.reg8, 32'h28); end
    step();
    n_cmp++;
    if (ifc.reg10 !== 32'h30 || ifc.reg9 !== 32'h0) begin
      n_bad++;
      $display("FAIL jalr_target: got x10=%h x9=%h want x10=%h x9=%h", ifc.reg10, ifc.reg9, 32'h30, 32'h0);
    end
    step();
    for (int k = 1; k <= 10; k++) begin
      logic [31:0] want;
      case (k)
        1: want = 32'h1;        2: want = 32'h80000000; 3: want = 32'h4;  4: want = 32'hF8000000;
        5: want = 32'hFFFFFFFF; 6: want = 32'h1;        7: want = 32'h31; 8: want = 32'h28;
        9: want = 32'h0;        default: want = 32'h30;
      endcase
      n_cmp++;
      if (rd_cus(k) !== want) begin
        n_bad++;
        $display("FAIL illegal_x%0d: got %h want %h", k, rd_cus(k), want);
      end
    end
    step();
    n_cmp++;
    if (ifc.reg9 !== 32'h38) begin n_bad++; $display("FAIL illegal_pc4: got %h want %h", ifc.reg9, 32'h38); end
    for (int e = 14; e <= 20; e++) step();
    n_cmp++;
    if (ifc.reg9 !== 32'h38 || ifc.reg10 !== 32'h30) begin
      n_bad++;
      $display("FAIL custom_final: got x9=%h x10=%h want x9=%h x10=%h", ifc.reg9, ifc.reg10, 32'h38, 32'h30);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_arith();
    test_memory();
    test_branch_loop();
    test_midrun_reset();
    test_custom_rom();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
